mem_lsu: RTL

//  MEM stage of the 5-stage MIPS pipeline; sits between the EX/MEM and MEM/WB pipeline registers.
//  Non-memory instructions pass through combinationally with zero latency.

---
 rtl/mem_lsu_pkg.sv | 69 ++++++
 rtl/mem_align.sv | 58 +++++
 rtl/mem_lsu.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: opcodes, lane masks,
// FSM encoding and opcode classification helpers.
package mem_lsu_pkg;

  localparam logic        RST_ENABLE = 1'b0;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

  localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [7:0] EXE_ADDU_OP = 8'b0010_0001;
  localparam logic [7:0] EXE_LB_OP   = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP   = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP   = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP  = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP  = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP   = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP   = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP   = 8'b1110_1011;

  localparam logic [3:0] SEL_NONE = 4'b0000;
  localparam logic [3:0] SEL_BYTE = 4'b0001;
  localparam logic [3:0] SEL_HI_H = 4'b1100;
  localparam logic [3:0] SEL_LO_H = 4'b0011;
  localparam logic [3:0] SEL_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_NONE = 2'b00,
    SZ_BYTE = 2'b01,
    SZ_HALF = 2'b10,
    SZ_WORD = 2'b11
  } acc_size_e;

  function automatic acc_size_e acc_size(input logic [7:0] op);
    acc_size_e sz;
    sz = SZ_NONE;
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: sz = SZ_BYTE;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: sz = SZ_HALF;
      EXE_LW_OP, EXE_SW_OP:             sz = SZ_WORD;
      default:                          sz = SZ_NONE;
    endcase
    return sz;
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

  function automatic logic is_mem_op(input logic [7:0] op);
    return acc_size(op) != SZ_NONE;
  endfunction

  function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (acc_size(op))
      SZ_HALF: mis = addr_lo[0];
      SZ_WORD: mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering: byte enables and replicated store data from
// the address, and the aligned, sign/zero-extended load result.
module mem_align
  import mem_lsu_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [7:0]  aluop,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] reg2,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] store_data,
  output logic [31:0] load_data
);

  logic [1:0]  byte_lane;
  logic        half_lane;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Lane numbers count from bit 0; big-endian puts address 0 in the top lane.
  always_comb begin
    byte_lane = BIG_ENDIAN ? ~addr_lo : addr_lo;
    half_lane = BIG_ENDIAN ? ~addr_lo[1] : addr_lo[1];
    ld_byte   = rdata[{byte_lane, 3'b000} +: 8];
    ld_half   = rdata[{half_lane, 4'b0000} +: 16];
  end

  always_comb begin
    sel        = SEL_NONE;
    store_data = reg2;
    case (acc_size(aluop))
      SZ_BYTE: begin
        sel        = SEL_BYTE << byte_lane;
        store_data = {4{reg2[7:0]}};
      end
      SZ_HALF: begin
        sel        = half_lane ? SEL_HI_H : SEL_LO_H;
        store_data = {2{reg2[15:0]}};
      end
      SZ_WORD: sel = SEL_WORD;
      default: sel = SEL_NONE;
    endcase
  end

  always_comb begin
    load_data = rdata;
    case (aluop)
      EXE_LB_OP:  load_data = {{24{ld_byte[7]}}, ld_byte};
      EXE_LBU_OP: load_data = {24'h000000, ld_byte};
      EXE_LH_OP:  load_data = {{16{ld_half[15]}}, ld_half};
      EXE_LHU_OP: load_data = {16'h0000, ld_half};
      default:    load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM pipeline stage: passes non-memory ops through and runs a registered
// req/ack bus transaction for loads/stores. Option: UNALIGNED_TRAP_EN.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 256,
  parameter bit          BIG_ENDIAN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_hi,
  input  logic [31:0] mem_lo,
  input  logic        mem_whilo,
  input  logic [7:0]  mem_aluop,
  input  logic [31:0] mem_mem_addr,
  input  logic [31:0] mem_reg2,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic [31:0] wb_hi,
  output logic [31:0] wb_lo,
  output logic        wb_whilo,
  output logic        stallreq_mem,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        dbus_err
`ifdef UNALIGNED_TRAP_EN
  ,
  output logic        exc_misaligned
`endif
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  lsu_state_e        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              abort_q, abort_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [3:0]        al_sel;
  logic [31:0]       al_store;
  logic [31:0]       al_load;
  logic              trap_hit;

  mem_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
    .aluop      (mem_aluop),
    .addr_lo    (mem_mem_addr[1:0]),
    .reg2       (mem_reg2),
    .rdata      (rdata_q),
    .sel        (al_sel),
    .store_data (al_store),
    .load_data  (al_load)
  );

`ifdef UNALIGNED_TRAP_EN
  assign trap_hit       = is_misaligned(mem_aluop, mem_mem_addr[1:0]);
  assign exc_misaligned = (state_q == ST_DONE) && abort_q && trap_hit;
`else
  assign trap_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    sel_d        = sel_q;
    wdata_d      = wdata_q;
    err_d        = 1'b0;
    abort_d      = abort_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    stallreq_mem = 1'b0;
    wb_wd        = mem_wd;
    wb_wreg      = mem_wreg;
    wb_wdata     = mem_wdata;
    wb_hi        = mem_hi;
    wb_lo        = mem_lo;
    wb_whilo     = mem_whilo;

    case (state_q)
      ST_IDLE: begin
        if (is_mem_op(mem_aluop)) begin
          stallreq_mem = 1'b1;
          if (trap_hit) begin
            abort_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            req_d   = 1'b1;
            we_d    = is_store(mem_aluop);
            addr_d  = {mem_mem_addr[31:2], 2'b00};
            sel_d   = al_sel;
            wdata_d = al_store;
            cnt_d   = '0;
            abort_d = 1'b0;
            state_d = ST_BUSY;
          end
        end
      end

      ST_BUSY: begin
        stallreq_mem = 1'b1;
        // Ack is checked first so a response on the last allowed cycle still completes.
        if (dbus_ack) begin
          rdata_d = dbus_rdata;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          abort_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        if (abort_q) begin
          wb_wreg  = 1'b0;
          wb_whilo = 1'b0;
        end else if (is_store(mem_aluop)) begin
          wb_wreg = 1'b0;
        end else begin
          wb_wdata = al_load;
        end
        abort_d = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= ZERO_WORD;
      sel_q   <= SEL_NONE;
      wdata_q <= ZERO_WORD;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= ZERO_WORD;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      abort_q <= abort_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign dbus_req   = req_q;
  assign dbus_we    = we_q;
  assign dbus_addr  = addr_q;
  assign dbus_sel   = sel_q;
  assign dbus_wdata = wdata_q;
  assign dbus_err   = err_q;

endmodule
